// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: scoreboard-based operand forwarding and load-use / mult-div stall generation beside ID.
// Define HAZARD_STATS_EN to add saturating stallCnt / mdStallCnt outputs.
module hazard_forward_unit #(
   parameter int REG_W      = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 1,
   parameter int MD_LAT     = 32,
   localparam int FWD_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             idValid,
   input  logic [REG_W-1:0] idRs,
   input  logic [REG_W-1:0] idRt,
   input  logic             idUseRs,
   input  logic             idUseRt,
   input  logic [REG_W-1:0] idDest,
   input  logic             idRegWrite,
   input  logic             idMemRead,
   input  logic             idMdStart,
   input  logic             idMdRead,
   output logic [FWD_W-1:0] fwdRs,
   output logic [FWD_W-1:0] fwdRt,
   output logic             stall,
`ifdef HAZARD_STATS_EN
   output logic [15:0]      stallCnt,
   output logic [15:0]      mdStallCnt,
`endif
   output logic             mdBusy
);
   localparam int MD_W = $clog2(MD_LAT + 1);

   logic [DEPTH-1:0] valid, is_load;
   logic [REG_W-1:0] dest [DEPTH];
   logic [MD_W-1:0]  md_cnt;
   logic             lu_rs, lu_rt, load_use, md_hazard;

   // Scan oldest to youngest so the youngest match overwrites older ones.
   always_comb begin
      fwdRs = '0;
      fwdRt = '0;
      lu_rs = 1'b0;
      lu_rt = 1'b0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (valid[k] && dest[k] == idRs && idUseRs && idRs != '0) begin
            fwdRs = FWD_W'(k + 1);
            lu_rs = is_load[k] && (k < LOAD_READY);
         end
         if (valid[k] && dest[k] == idRt && idUseRt && idRt != '0) begin
            fwdRt = FWD_W'(k + 1);
            lu_rt = is_load[k] && (k < LOAD_READY);
         end
      end
   end

   assign load_use  = lu_rs | lu_rt;
   assign mdBusy    = md_cnt != '0;
   assign md_hazard = mdBusy & (idMdRead | idMdStart);
   assign stall     = idValid & (load_use | md_hazard);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid   <= '0;
         is_load <= '0;
         md_cnt  <= '0;
         for (int k = 0; k < DEPTH; k++) dest[k] <= '0;
      end else begin
         for (int k = 1; k < DEPTH; k++) begin
            valid[k]   <= valid[k-1];
            is_load[k] <= is_load[k-1];
            dest[k]    <= dest[k-1];
         end
         valid[0]   <= !stall && idValid && idRegWrite && idDest != '0;
         is_load[0] <= idMemRead;
         dest[0]    <= idDest;
         if (idMdStart && idValid && !stall) md_cnt <= MD_W'(MD_LAT);
         else if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stallCnt   <= '0;
         mdStallCnt <= '0;
      end else begin
         if (stall && stallCnt != 16'hFFFF) stallCnt <= stallCnt + 16'd1;
         if (stall && md_hazard && mdStallCnt != 16'hFFFF) mdStallCnt <= mdStallCnt + 16'd1;
      end
   end
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors for hazard_forward_unit with hand-computed expectations.
module tb_hazard_forward_unit;
   logic       clk = 1'b0;
   logic       reset;
   logic       idValid, idUseRs, idUseRt, idRegWrite, idMemRead, idMdStart, idMdRead;
   logic [4:0] idRs, idRt, idDest;
   logic [1:0] fwdRs, fwdRt;
   logic       stall, mdBusy;
`ifdef HAZARD_STATS_EN
   logic [15:0] stallCnt, mdStallCnt;
`endif
   int checks = 0;
   int fails  = 0;

   hazard_forward_unit dut (
      .clk(clk), .reset(reset), .idValid(idValid), .idRs(idRs), .idRt(idRt),
      .idUseRs(idUseRs), .idUseRt(idUseRt), .idDest(idDest), .idRegWrite(idRegWrite),
      .idMemRead(idMemRead), .idMdStart(idMdStart), .idMdRead(idMdRead),
      .fwdRs(fwdRs), .fwdRt(fwdRt), .stall(stall),
`ifdef HAZARD_STATS_EN
      .stallCnt(stallCnt), .mdStallCnt(mdStallCnt),
`endif
      .mdBusy(mdBusy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Present one ID instruction mid-cycle and let the combinational outputs settle.
   task automatic id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                     input int dst, input logic rw, input logic mr, input logic ms, input logic md);
      @(negedge clk);
      idValid = v; idRs = 5'(rs); idRt = 5'(rt); idUseRs = urs; idUseRt = urt;
      idDest = 5'(dst); idRegWrite = rw; idMemRead = mr; idMdStart = ms; idMdRead = md;
      #1;
   endtask

   initial begin
      int n, busy_bad;
      reset = 1'b1;
      id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_fwdRs", fwdRs, 0);
      check("rst_fwdRt", fwdRt, 0);
      check("rst_stall", stall, 0);
      check("rst_mdBusy", mdBusy, 0);

      id(1, 1, 2, 1, 1, 3, 1, 0, 0, 0);
      check("add3_stall", stall, 0);
      id(1, 3, 2, 1, 1, 10, 1, 0, 0, 0);
      check("sub_fwdRs", fwdRs, 1);
      check("sub_stall", stall, 0);

      id(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
      id(1, 1, 2, 1, 1, 11, 1, 0, 0, 0);
      id(1, 1, 5, 0, 1, 12, 1, 0, 0, 0);
      check("rt5_age1", fwdRt, 2);
      id(1, 1, 5, 0, 1, 12, 1, 0, 0, 0);
      check("rt5_age2", fwdRt, 3);
      id(1, 1, 5, 0, 1, 12, 1, 0, 0, 0);
      check("rt5_expired", fwdRt, 0);

      id(1, 1, 0, 1, 0, 4, 1, 1, 0, 0);
      id(1, 4, 2, 1, 1, 13, 1, 0, 0, 0);
      check("lu_rs_stall", stall, 1);
      id(1, 4, 2, 1, 1, 13, 1, 0, 0, 0);
      check("lu_rs_release", stall, 0);
      check("lu_rs_fwd", fwdRs, 2);

      id(1, 1, 0, 1, 0, 6, 1, 1, 0, 0);
      id(1, 1, 6, 1, 1, 14, 1, 0, 0, 0);
      check("lu_rt_stall", stall, 1);
      id(1, 1, 6, 1, 1, 14, 1, 0, 0, 0);
      check("lu_rt_release", stall, 0);
      check("lu_rt_fwd", fwdRt, 2);

      id(1, 1, 2, 1, 1, 0, 1, 1, 0, 0);
      id(1, 0, 0, 1, 1, 15, 1, 0, 0, 0);
      check("r0_fwdRs", fwdRs, 0);
      check("r0_stall", stall, 0);

      id(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
      id(1, 1, 2, 1, 1, 7, 1, 0, 0, 0);
      id(1, 7, 7, 1, 0, 16, 1, 0, 0, 0);
      check("r7_youngest", fwdRs, 1);
      check("r7_unused_rt", fwdRt, 0);

      id(1, 1, 2, 1, 1, 8, 1, 1, 0, 0);
      id(0, 8, 2, 1, 0, 0, 0, 0, 0, 0);
      check("invalid_nostall", stall, 0);
      id(1, 8, 2, 1, 0, 17, 1, 0, 0, 0);
      check("bubble_fwd", fwdRs, 2);
      check("bubble_stall", stall, 0);

      id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      check("mult_stall", stall, 0);
      check("mult_idle", mdBusy, 0);
      n = 0;
      busy_bad = 0;
      id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      while (stall && n < 40) begin
         n++;
         if (!mdBusy) busy_bad++;
         id(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      end
      check("mfhi_stall_cycles", n, 32);
      check("mfhi_busy_during", busy_bad, 0);
      check("mfhi_busy_fall", mdBusy, 0);
      check("mfhi_proceeds", stall, 0);

      id(1, 1, 2, 1, 1, 9, 1, 0, 0, 0);
      id(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      id(1, 9, 0, 1, 0, 0, 0, 0, 0, 1);
      check("pre_rst_fwd", fwdRs, 2);
      check("pre_rst_stall", stall, 1);
      check("pre_rst_busy", mdBusy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      id(1, 9, 9, 1, 1, 0, 0, 0, 0, 1);
      check("post_rst_fwdRs", fwdRs, 0);
      check("post_rst_fwdRt", fwdRt, 0);
      check("post_rst_stall", stall, 0);
      check("post_rst_busy", mdBusy, 0);
`ifdef HAZARD_STATS_EN
      check("post_rst_stallCnt", stallCnt, 0);
      check("post_rst_mdStallCnt", mdStallCnt, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the combinational forwarding logic: holds its own scoreboard of in-flight destination registers across DEPTH post-ID stages.
- Issues a forwarding select per source operand and a pipeline stall for load-use and multiply/divide hazards.
- Sits beside the ID stage. Consumes the decoded ID instruction and drives the operand muxes and the PC/IF-ID hold logic.

Parameters:
- REG_W, 5: register address width.
- DEPTH, 3: number of tracked stages after ID (entry 0 = EX, 1 = MEM, 2 = WB).
- LOAD_READY, 1: lowest entry index at which load data is forwardable.
- MD_LAT, 32: multiply/divide busy cycles.
- Derived localparam FWD_W = $clog2(DEPTH+1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- idValid  in  1  ID holds a real instruction.
- idRs, idRt  in  REG_W  source register numbers.
- idUseRs, idUseRt  in  1  operand actually read.
- idDest  in  REG_W  destination register.
- idRegWrite  in  1  instruction writes idDest.
- idMemRead  in  1  instruction is a load.
- idMdStart  in  1  mult/div issue.
- idMdRead  in  1  mfhi/mflo.
- fwdRs, fwdRt  out  FWD_W  0 = register file; k = forward from entry k-1.
- stall  out  1  hold PC and IF/ID; bubble into EX.
- mdBusy  out  1  mult/div unit running.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port reset.
- Scoreboard: DEPTH entries of {valid, dest[REG_W], isLoad}.
- Every rising edge: entry[k] <= entry[k-1] for k = 1..DEPTH-1. The oldest entry is dropped.
- entry[0] load when stall=0: valid = idValid & idRegWrite & (idDest != 0); dest = idDest; isLoad = idMemRead.
- entry[0] load when stall=1: bubble (valid=0). Older entries still advance.
- Forward select: fwdRs = k+1 for the smallest k with entry[k].valid & entry[k].dest == idRs & idUseRs & idRs != 0. Otherwise 0. Youngest match wins. fwdRt is identical using idRt/idUseRt.
- Load-use: asserted when the youngest matching entry for either used operand has isLoad=1 and index k < LOAD_READY.
- MD counter: mdCnt is $clog2(MD_LAT+1) bits.
  - idMdStart & idValid & !stall: mdCnt <= MD_LAT.
  - Otherwise, if mdCnt != 0: decrement.
  - mdBusy = (mdCnt != 0).
- mdHazard = mdBusy & (idMdRead | idMdStart).
- stall = idValid & (loadUse | mdHazard).
- All outputs are combinational from registered state plus ID inputs. No internal path from stall back to stall.
- Reset: all entries invalid, mdCnt = 0. With idValid=0, outputs are fwdRs = fwdRt = 0, stall = 0, mdBusy = 0.
- Reset mid-operation: reset wins over any shift or counter load in the same cycle.
- Register 0: never tracked and never forwarded.
- Simultaneous hazards: loadUse and mdHazard in the same cycle produce a single stall. Entry[0] takes a bubble.
- idValid=0: no stall, and entry[0] becomes a bubble.
- Lifetime: a writer drops out of forwarding after DEPTH cycles. The register file must then supply the value (write-before-read register file).

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: adds output ports stallCnt[15:0] and mdStallCnt[15:0].
  - stallCnt increments on every cycle with stall=1.
  - mdStallCnt increments on cycles where stall=1 due to mdHazard.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: no counters and no extra ports. Base behaviour is unchanged.

Test Plan:
- add $3 issued, next cycle sub uses $3 as rs -> fwdRs=1, stall=0.
- Writer of $5, one independent instruction, then reader of $5 as rt -> fwdRt=2. After a further independent instruction -> fwdRt=3. One cycle later -> 0.
- lw $4, then add with rs=$4 next cycle -> stall=1 for exactly 1 cycle. Following cycle: fwdRs=2, stall=0.
- Writer of $0, then reader of $0 -> fwdRs=0, stall=0. Also: two in-flight writers of $7 -> the younger one selected.
- mult issued, then mfhi on the next cycle -> stall=1 and mdBusy=1 for MD_LAT cycles (32). mfhi proceeds on the cycle mdBusy falls.
- Reset asserted during the mult wait and with valid entries -> next cycle all outputs 0, no forwarding to prior dests. With HAZARD_STATS_EN, stallCnt reads 0.
